// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one ALU operation per accepted request.
// The block decodes the op class into one-hot ALU controls and holds them stable.
// It captures the ALU status outputs and pulses the flag write strobes.
// It then enables the stored result onto SB or ADL.
//
// Handshake: a request is taken on the posedge where req_valid && req_ready.
// req_ready is high only in IDLE and outside reset. req_op, req_dst, p_c and
// p_d are sampled on that edge and never looked at again for this op.
// The requester holds aIn/bIn while busy is high.
module alu_op_sequencer #(
    parameter int OPW       = 4,
    parameter int DEC_EXTRA = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [OPW-1:0] req_op,
    input  logic           req_dst,
    input  logic           p_c,
    input  logic           p_d,
    input  logic           alu_cout,
    input  logic           alu_zero,
    input  logic           alu_ovf,
    input  logic           alu_neg,
    output logic           alu_sums,
    output logic           alu_subs,
    output logic           alu_ands,
    output logic           alu_eors,
    output logic           alu_ors,
    output logic           alu_shftr,
    output logic           alu_shftcr,
    output logic           alu_decen,
    output logic           alu_cin,
    output logic           alu_reset,
    output logic           alu_sboa,
    output logic           alu_adloa,
    output logic           busy,
    output logic [3:0]     flag_we,
    output logic [3:0]     flag_val,
    output logic           done,
    output logic           err,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        DSET = 3'd2,
        CAPT = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t     state, state_n;
    logic       accept;
    logic       legal;
    logic [6:0] ctrl_d, ctrl_q;    // {sums,subs,ands,eors,ors,shftr,shftcr}
    logic       cin_d, cin_q;
    logic       decen_d, decen_q;
    logic [3:0] mask_d, mask_q;    // {N,V,Z,C} write mask
    logic       cmp_d, cmp_q;
    logic       dst_q;
    logic [3:0] flags_q;           // captured {N,V,Z,C}
    logic       err_q;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign legal     = (req_op < OPW'(8));

    // Decode the requested op class into controls, carry-in and flag mask
    always_comb begin
        ctrl_d  = 7'b0;
        cin_d   = 1'b0;
        mask_d  = 4'b0;
        cmp_d   = 1'b0;
        decen_d = 1'b0;
        case (req_op[2:0])
            3'd0: begin ctrl_d = 7'b1000000; cin_d = p_c; decen_d = p_d; end
            3'd1: begin ctrl_d = 7'b0100000; cin_d = p_c; decen_d = p_d; end
            3'd2: ctrl_d = 7'b0010000;
            3'd3: ctrl_d = 7'b0001000;
            3'd4: ctrl_d = 7'b0000100;
            3'd5: ctrl_d = 7'b0000010;
            3'd6: begin ctrl_d = 7'b0000001; cin_d = p_c; end
            default: begin ctrl_d = 7'b0100000; cin_d = 1'b1; cmp_d = 1'b1; end
        endcase
        if (req_op[2:0] <= 3'd1)
            mask_d = decen_d ? 4'b1011 : 4'b1111;
        else if (req_op[2:0] <= 3'd4)
            mask_d = 4'b1010;
        else
            mask_d = 4'b1011;
    end

    // Next-state logic for the operation sequence
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept && legal) state_n = EXEC;
            EXEC: state_n = (decen_q && (DEC_EXTRA != 0)) ? DSET : CAPT;
            DSET: state_n = CAPT;
            CAPT: state_n = cmp_q ? IDLE : OUT;
            OUT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register, latched request, held controls and flag capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ctrl_q  <= 7'b0;
            cin_q   <= 1'b0;
            decen_q <= 1'b0;
            mask_q  <= 4'b0;
            cmp_q   <= 1'b0;
            dst_q   <= 1'b0;
            flags_q <= 4'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= accept && !legal;
            if (accept && legal) begin
                ctrl_q  <= ctrl_d;
                cin_q   <= cin_d;
                decen_q <= decen_d;
                mask_q  <= mask_d;
                cmp_q   <= cmp_d;
                dst_q   <= req_dst;
            end else if (state_n == IDLE) begin
                ctrl_q  <= 7'b0;
                cin_q   <= 1'b0;
                decen_q <= 1'b0;
            end
            // Status is taken on the edge that ends the last EXEC/DSET cycle
            if ((state == EXEC || state == DSET) && state_n == CAPT)
                flags_q <= {alu_neg, alu_ovf, alu_zero, alu_cout};
        end
    end

    assign {alu_sums, alu_subs, alu_ands, alu_eors, alu_ors, alu_shftr, alu_shftcr} = ctrl_q;
    assign alu_cin   = cin_q;
    assign alu_decen = decen_q;
    assign alu_reset = reset;
    assign busy      = (state != IDLE);
    assign err       = err_q;
    assign dbg_state = state;

    // Strobes are gated by reset so an aborted op never writes flags or completes
    assign flag_we   = (state == CAPT && !reset) ? mask_q : 4'b0;
    assign flag_val  = flag_we & flags_q;
    assign done      = !reset && ((state == OUT) || (state == CAPT && cmp_q));
    assign alu_sboa  = !reset && (state == OUT) && !dst_q;
    assign alu_adloa = !reset && (state == OUT) && dst_q;

endmodule
